axi_rw_arbiter: RTL and testbench
=================================

Name: axi_rw_arbiter

Overview:
Sequences the single shared bus master between two requesters: instruction fetch (read-only) and the memory stage (read/write). Only one transaction is outstanding at a time. It sits between the IF/MEM stages and the AXI bridge. Memory-stage requests have priority, and a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
STARVE_LIMIT, 4, consecutive MEM grants allowed while IF is waiting; range 1..15

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
if_valid  in  1  fetch request
if_ready  out  1  fetch response strobe, one cycle
inst_addr  in  ADDR_W  fetch address
if_data_read  out  DATA_W  fetch data, valid when if_ready=1
mem_valid  in  1  memory-stage request
mem_write  in  1  1=store, 0=load
mem_addr  in  ADDR_W  load/store address
mem_wdata  in  DATA_W  store data
mem_wstrb  in  DATA_W/8  store byte strobes
mem_size  in  2  0=byte, 1=half, 2=word, 3=dword
mem_ready  out  1  memory response strobe, one cycle
mem_rdata  out  DATA_W  load data, valid when mem_ready=1
bus_req_valid  out  1  request to bridge
bus_req_ready  in  1  bridge accepts request
bus_req_write  out  1  write request
bus_req_addr  out  ADDR_W  request address
bus_req_wdata  out  DATA_W  write data
bus_req_wstrb  out  DATA_W/8  write strobes
bus_req_size  out  2  transfer size
bus_resp_valid  in  1  bridge response, one cycle
bus_resp_rdata  in  DATA_W  response data
grant_mem  out  1  current or last grant owner; 1=MEM, 0=IF (debug/perf)

Behaviour:
- Reset (async, active-high):
  - state=IDLE; starve_cnt=0; grant_mem=0.
  - bus_req_valid, bus_req_write, if_ready and mem_ready are all 0.
  - Latched request registers are 0.
- States: IDLE, REQ, WAIT.
- IDLE, arbitration:
  - mem_valid wins unless if_valid=1 and starve_cnt==STARVE_LIMIT.
  - Winner's fields are latched into request registers on the clock edge and the state moves to REQ.
  - IF grants force write=0, size=3, wstrb=0, wdata=0.
  - No valid asserted: stay in IDLE.
- REQ:
  - bus_req_valid=1; all bus_req_* come from registers, never combinationally from requester inputs.
  - Fields stay stable until bus_req_ready=1.
  - On bus_req_valid && bus_req_ready, go to WAIT.
- WAIT:
  - On bus_resp_valid, assert the granted requester's ready combinationally in that same cycle.
  - The matching data output is a direct pass-through of bus_resp_rdata.
  - Next state is IDLE.
  - Ignore bus_resp_valid in IDLE/REQ (protocol error; no response strobe).
- Latency: minimum 3 cycles from request to ready — IDLE grant, REQ with ready=1 in the same cycle, WAIT with response in the same cycle.
- Response-to-next-request: one IDLE cycle. A requester whose valid stays high after its ready is re-arbitrated next cycle with its current inputs. IF updates inst_addr on handshake, so back-to-back fetch works.
- Requester valid dropping after grant: the transaction completes and the ready strobe is still issued; the requester ignores it.
- if_data_read/mem_rdata: when the associated ready=0 the value is don't-care; drive bus_resp_rdata.
- starve_cnt (4 bit):
  - Increments on a MEM grant while if_valid=1, saturating at STARVE_LIMIT.
  - Clears on any IF grant, or on a MEM grant with if_valid=0.
- grant_mem updates on each grant and holds otherwise.
- Reset mid-transaction: abandon immediately. The bridge shares rst, so no orphan response is expected.

Test Plan:
- IF only: inst_addr=0x80000000, if_valid=1, bridge ready immediately, resp 1 cycle later with rdata=0x00000013 -> bus_req_addr=0x80000000, write=0, size=3; if_ready=1 on cycle 3 with if_data_read=0x13; mem_ready stays 0.
- MEM store: mem_write=1, addr=0x80001008, wdata=0xDEADBEEF, wstrb=0x0F, size=2 -> bus_req fields match exactly; mem_ready pulses once on response; if_ready stays 0.
- Simultaneous if_valid and mem_valid in IDLE -> MEM granted first (grant_mem=1); IF granted on the next IDLE; two transactions, in order.
- Starvation, STARVE_LIMIT=4: mem_valid and if_valid held high -> grant order MEM,MEM,MEM,MEM,IF,MEM...; starve_cnt returns to 0 after the IF grant.
- Backpressure: bus_req_ready=0 for 5 cycles in REQ while requester inputs toggle -> bus_req_valid stays 1; addr/wdata/wstrb/size are unchanged; WAIT is entered only after ready=1.
- Reset asserted mid-WAIT -> outputs are zero immediately (async); state IDLE after release; first post-reset request completes normally.

Source files
------------

// File: rtl/axi_rw_arbiter.sv
// Single-outstanding arbiter sharing one bus master between instruction fetch
// (read-only) and the memory stage (read/write), MEM-priority with fetch anti-starvation.
module axi_rw_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     if_data_read,

    input  logic                  mem_valid,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [1:0]            mem_size,
    output logic                  mem_ready,
    output logic [DATA_W-1:0]     mem_rdata,

    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_req_write,
    output logic [ADDR_W-1:0]     bus_req_addr,
    output logic [DATA_W-1:0]     bus_req_wdata,
    output logic [DATA_W/8-1:0]   bus_req_wstrb,
    output logic [1:0]            bus_req_size,
    input  logic                  bus_resp_valid,
    input  logic [DATA_W-1:0]     bus_resp_rdata,

    output logic                  grant_mem
);

    localparam int          STRB_W  = DATA_W / 8;
    localparam logic [3:0]  LIMIT_C = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_n;
    logic [3:0]          starve_cnt_r;
    logic [3:0]          starve_cnt_n;
    logic                grant_mem_r;
    logic                bus_req_valid_r;
    logic                req_write_r;
    logic [ADDR_W-1:0]   req_addr_r;
    logic [DATA_W-1:0]   req_wdata_r;
    logic [STRB_W-1:0]   req_wstrb_r;
    logic [1:0]          req_size_r;

    logic                grant_if_s;
    logic                grant_mem_s;
    logic                resp_hit_s;

    // MEM wins unless fetch is waiting and has already been passed over LIMIT times.
    function automatic logic mem_wins(input logic if_v, input logic mem_v, input logic [3:0] cnt);
        return mem_v && !(if_v && (cnt == LIMIT_C));
    endfunction

    // Next-state decode and arbitration strobes
    always_comb begin
        state_n     = state_r;
        grant_if_s  = 1'b0;
        grant_mem_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_wins(if_valid, mem_valid, starve_cnt_r)) begin
                    grant_mem_s = 1'b1;
                    state_n     = REQ;
                end else if (if_valid) begin
                    grant_if_s  = 1'b1;
                    state_n     = REQ;
                end else begin
                    state_n     = IDLE;
                end
            end
            REQ: begin
                if (bus_req_valid_r && bus_req_ready) begin
                    state_n = WAIT;
                end else begin
                    state_n = REQ;
                end
            end
            WAIT: begin
                if (bus_resp_valid) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Starvation counter: saturating count of MEM grants that bypassed a waiting fetch
    always_comb begin
        starve_cnt_n = starve_cnt_r;
        if (grant_mem_s) begin
            if (if_valid) begin
                if (starve_cnt_r == LIMIT_C) begin
                    starve_cnt_n = starve_cnt_r;
                end else begin
                    starve_cnt_n = starve_cnt_r + 4'd1;
                end
            end else begin
                starve_cnt_n = 4'd0;
            end
        end else if (grant_if_s) begin
            starve_cnt_n = 4'd0;
        end else begin
            starve_cnt_n = starve_cnt_r;
        end
    end

    // State, counter, grant owner and request-valid registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            starve_cnt_r    <= 4'd0;
            grant_mem_r     <= 1'b0;
            bus_req_valid_r <= 1'b0;
        end else begin
            state_r         <= state_n;
            starve_cnt_r    <= starve_cnt_n;
            bus_req_valid_r <= (state_n == REQ);
            if (grant_mem_s) begin
                grant_mem_r <= 1'b1;
            end else if (grant_if_s) begin
                grant_mem_r <= 1'b0;
            end else begin
                grant_mem_r <= grant_mem_r;
            end
        end
    end

    // Latch the winner's request so the bus side never sees live requester inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_write_r <= 1'b0;
            req_addr_r  <= {ADDR_W{1'b0}};
            req_wdata_r <= {DATA_W{1'b0}};
            req_wstrb_r <= {STRB_W{1'b0}};
            req_size_r  <= 2'd0;
        end else if (grant_mem_s) begin
            req_write_r <= mem_write;
            req_addr_r  <= mem_addr;
            req_wdata_r <= mem_wdata;
            req_wstrb_r <= mem_wstrb;
            req_size_r  <= mem_size;
        end else if (grant_if_s) begin
            req_write_r <= 1'b0;
            req_addr_r  <= inst_addr;
            req_wdata_r <= {DATA_W{1'b0}};
            req_wstrb_r <= {STRB_W{1'b0}};
            req_size_r  <= 2'd3;
        end else begin
            req_write_r <= req_write_r;
            req_addr_r  <= req_addr_r;
            req_wdata_r <= req_wdata_r;
            req_wstrb_r <= req_wstrb_r;
            req_size_r  <= req_size_r;
        end
    end

    // Responses outside WAIT are protocol errors and must not produce a strobe.
    assign resp_hit_s    = (state_r == WAIT) && bus_resp_valid;

    assign if_ready      = resp_hit_s && !grant_mem_r;
    assign mem_ready     = resp_hit_s &&  grant_mem_r;
    assign if_data_read  = bus_resp_rdata;
    assign mem_rdata     = bus_resp_rdata;

    assign bus_req_valid = bus_req_valid_r;
    assign bus_req_write = req_write_r;
    assign bus_req_addr  = req_addr_r;
    assign bus_req_wdata = req_wdata_r;
    assign bus_req_wstrb = req_wstrb_r;
    assign bus_req_size  = req_size_r;
    assign grant_mem     = grant_mem_r;

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed plus randomized bench for axi_rw_arbiter against a transaction-level
// model of the arbitration and starvation rules.
module tb_axi_rw_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] inst_addr;
    logic [63:0] if_data_read;
    logic        mem_valid;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic [1:0]  mem_size;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_write;
    logic [63:0] bus_req_addr;
    logic [63:0] bus_req_wdata;
    logic [7:0]  bus_req_wstrb;
    logic [1:0]  bus_req_size;
    logic        bus_resp_valid;
    logic [63:0] bus_resp_rdata;
    logic        grant_mem;

    int checks = 0;
    int errors = 0;

    // Reference model state: fetch-bypass count, last owner, last winner (0 none, 1 IF, 2 MEM)
    int m_starve   = 0;
    bit m_grant    = 1'b0;
    int last_win   = 0;

    axi_rw_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .inst_addr(inst_addr), .if_data_read(if_data_read),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_size(mem_size), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_write(bus_req_write),
        .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
        .bus_req_size(bus_req_size), .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
        .grant_mem(grant_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_fields();
        inst_addr = {$urandom, $urandom};
        mem_write = 1'($urandom_range(0, 1));
        mem_addr  = {$urandom, $urandom};
        mem_wdata = {$urandom, $urandom};
        mem_wstrb = 8'($urandom_range(0, 255));
        mem_size  = 2'($urandom_range(0, 3));
    endtask

    // One full transaction starting from IDLE at a negedge; requester fields preset by caller.
    task automatic do_txn(input bit ifv, input bit memv, input int rdy_dly, input int rsp_dly,
                          input logic [63:0] rdata, input bit toggle, input bit abort);
        int          win;
        logic        e_w;
        logic [63:0] e_a;
        logic [63:0] e_d;
        logic [7:0]  e_s;
        logic [1:0]  e_z;
        if_valid  = ifv;
        mem_valid = memv;
        if (memv && !(ifv && m_starve == LIMIT)) win = 2;
        else if (ifv)                            win = 1;
        else                                     win = 0;
        if (win == 2) begin
            m_starve = ifv ? ((m_starve < LIMIT) ? m_starve + 1 : m_starve) : 0;
            m_grant  = 1'b1;
            e_w = mem_write; e_a = mem_addr; e_d = mem_wdata; e_s = mem_wstrb; e_z = mem_size;
        end else begin
            if (win == 1) begin
                m_starve = 0;
                m_grant  = 1'b0;
            end
            e_w = 1'b0; e_a = inst_addr; e_d = 64'd0; e_s = 8'd0; e_z = 2'd3;
        end
        last_win = win;
        #1 chk("idle_valid", 64'(bus_req_valid), 64'd0);
        next_cycle();
        if (win == 0) begin
            chk("stay_idle", 64'(bus_req_valid), 64'd0);
            chk("idle_grant", 64'(grant_mem), 64'(m_grant));
            return;
        end
        for (int c = 0; c <= rdy_dly; c++) begin
            bus_req_ready  = (c == rdy_dly);
            bus_resp_valid = (c == rdy_dly) ? 1'b0 : 1'($urandom_range(0, 1));
            bus_resp_rdata = {$urandom, $urandom};
            if (toggle) begin
                if_valid  = 1'($urandom_range(0, 1));
                mem_valid = 1'($urandom_range(0, 1));
                rand_fields();
            end
            #1;
            chk("req_valid", 64'(bus_req_valid), 64'd1);
            chk("req_write", 64'(bus_req_write), 64'(e_w));
            chk("req_addr",  bus_req_addr, e_a);
            chk("req_wdata", bus_req_wdata, e_d);
            chk("req_wstrb", 64'(bus_req_wstrb), 64'(e_s));
            chk("req_size",  64'(bus_req_size), 64'(e_z));
            chk("req_grant", 64'(grant_mem), 64'(m_grant));
            chk("req_no_rdy", 64'({if_ready, mem_ready}), 64'd0);
            next_cycle();
        end
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        #1 chk("wait_valid", 64'(bus_req_valid), 64'd0);
        if (abort) begin
            bus_resp_valid = 1'b1;
            bus_resp_rdata = rdata;
            rst = 1'b1;
            #1;
            chk("rst_ready", 64'({if_ready, mem_ready}), 64'd0);
            chk("rst_grant", 64'(grant_mem), 64'd0);
            chk("rst_addr",  bus_req_addr, 64'd0);
            chk("rst_write", 64'(bus_req_write), 64'd0);
            chk("rst_valid", 64'(bus_req_valid), 64'd0);
            next_cycle();
            bus_resp_valid = 1'b0;
            if_valid  = 1'b0;
            mem_valid = 1'b0;
            rst = 1'b0;
            m_starve = 0;
            m_grant  = 1'b0;
            return;
        end
        for (int c = 0; c < rsp_dly; c++) begin
            #1 chk("wait_no_rdy", 64'({if_ready, mem_ready}), 64'd0);
            next_cycle();
        end
        bus_resp_valid = 1'b1;
        bus_resp_rdata = rdata;
        #1;
        chk("if_ready",  64'(if_ready),  64'(win == 1));
        chk("mem_ready", 64'(mem_ready), 64'(win == 2));
        if (win == 1) chk("if_data", if_data_read, rdata);
        else          chk("mem_data", mem_rdata, rdata);
        next_cycle();
        bus_resp_valid = 1'b0;
        if_valid  = 1'b0;
        mem_valid = 1'b0;
        #1 chk("strobe_once", 64'({if_ready, mem_ready}), 64'd0);
    endtask

    int exp_order [6] = '{2, 2, 2, 2, 1, 2};

    initial begin
        rst = 1'b1;
        if_valid = 1'b0; mem_valid = 1'b0; bus_req_ready = 1'b0;
        bus_resp_valid = 1'b0; bus_resp_rdata = 64'd0;
        inst_addr = 64'd0; mem_write = 1'b0; mem_addr = 64'd0; mem_wdata = 64'd0;
        mem_wstrb = 8'd0; mem_size = 2'd0;
        @(negedge clk);
        #1;
        chk("reset_valid", 64'(bus_req_valid), 64'd0);
        chk("reset_write", 64'(bus_req_write), 64'd0);
        chk("reset_ready", 64'({if_ready, mem_ready}), 64'd0);
        chk("reset_grant", 64'(grant_mem), 64'd0);
        chk("reset_addr",  bus_req_addr, 64'd0);
        chk("reset_size",  64'(bus_req_size), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fetch only, minimum latency
        inst_addr = 64'h0000_0000_8000_0000;
        do_txn(1'b1, 1'b0, 0, 0, 64'h13, 1'b0, 1'b0);
        chk("if_only_win", 64'(last_win), 64'd1);

        // Store from the memory stage
        mem_write = 1'b1; mem_addr = 64'h0000_0000_8000_1008; mem_wdata = 64'hDEAD_BEEF;
        mem_wstrb = 8'h0F; mem_size = 2'd2;
        do_txn(1'b0, 1'b1, 0, 0, 64'h0, 1'b0, 1'b0);
        chk("store_win", 64'(last_win), 64'd2);

        // Simultaneous requests: MEM first, then the still-waiting fetch
        rand_fields();
        do_txn(1'b1, 1'b1, 0, 0, {$urandom, $urandom}, 1'b0, 1'b0);
        chk("simul_first", 64'(last_win), 64'd2);
        rand_fields();
        do_txn(1'b1, 1'b0, 0, 0, {$urandom, $urandom}, 1'b0, 1'b0);
        chk("simul_second", 64'(last_win), 64'd1);

        // Starvation pattern with both requesters held high
        for (int i = 0; i < 6; i++) begin
            rand_fields();
            do_txn(1'b1, 1'b1, 0, 1, {$urandom, $urandom}, 1'b0, 1'b0);
            chk($sformatf("starve_order%0d", i), 64'(last_win), 64'(exp_order[i]));
        end

        // Backpressure with requester inputs toggling during REQ
        rand_fields();
        do_txn(1'b0, 1'b1, 5, 1, {$urandom, $urandom}, 1'b1, 1'b0);

        // Reset during WAIT, then a normal fetch
        rand_fields();
        mem_addr = 64'h0000_0000_8000_2000;
        do_txn(1'b0, 1'b1, 0, 0, 64'h55, 1'b0, 1'b1);
        rand_fields();
        do_txn(1'b1, 1'b0, 0, 0, {$urandom, $urandom}, 1'b0, 1'b0);
        chk("post_reset_win", 64'(last_win), 64'd1);

        // Stray response in IDLE must be ignored
        bus_resp_valid = 1'b1;
        #1 chk("stray_ready", 64'({if_ready, mem_ready}), 64'd0);
        next_cycle();
        bus_resp_valid = 1'b0;
        chk("stray_idle", 64'(bus_req_valid), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            rand_fields();
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
